// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue (former cpu_define.v macros).
package inst_queue_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned IQ_DEPTH = 16;
    localparam int unsigned IQ_IDX_W = $clog2(IQ_DEPTH);

    typedef logic [INST_W-1:0]   inst_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [IQ_IDX_W-1:0] iq_idx_t;

    localparam logic  VALID     = 1'b1;
    localparam logic  INVALID   = 1'b0;
    localparam logic  IQ_FULL   = 1'b1;
    localparam inst_t NULL_INST = '0;
    localparam addr_t NULL_ADDR = '0;

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with show-ahead head and early almost-full flag.
// Optional same-cycle bypass on an empty queue: define IQ_BYPASS_EN.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rdy,
    input  logic  clear,
    input  logic  if_inst_valid,
    input  inst_t if_inst,
    input  addr_t if_pc,
    output logic  iq_full,
    output logic  dec_inst_valid,
    output inst_t dec_inst,
    output addr_t dec_pc,
    input  logic  dec_ready
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FULL_TH_C = CNT_W'(DEPTH - 1);

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             iq_full_q, iq_full_d;

    inst_t inst_mem_q [DEPTH];
    addr_t pc_mem_q   [DEPTH];

    logic clr_eff;
    logic stored;
    logic byp;
    logic byp_take;
    logic push;
    logic pop;

    always_comb begin
        clr_eff = rdy && clear;
        stored  = (count_q != '0);
`ifdef IQ_BYPASS_EN
        byp = !stored && if_inst_valid && !clr_eff;
`else
        byp = 1'b0;
`endif
        byp_take = byp && dec_ready;

        dec_inst_valid = INVALID;
        dec_inst       = NULL_INST;
        dec_pc         = NULL_ADDR;
        if (!clr_eff && stored) begin
            dec_inst_valid = VALID;
            dec_inst       = inst_mem_q[head_q];
            dec_pc         = pc_mem_q[head_q];
        end else if (byp) begin
            dec_inst_valid = VALID;
            dec_inst       = if_inst;
            dec_pc         = if_pc;
        end

        // A pop on a full queue frees the head slot, which is exactly where tail points.
        pop  = !clr_eff && stored && dec_ready;
        push = !clr_eff && if_inst_valid && !byp_take && ((count_q < DEPTH_C) || pop);

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr_eff) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + IDX_W'(1);
            if (pop)  head_d = head_q + IDX_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        iq_full_d = (count_d >= FULL_TH_C) ? IQ_FULL : ~IQ_FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            iq_full_q <= 1'b0;
        end else if (rdy) begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            iq_full_q <= iq_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && push) begin
            inst_mem_q[tail_q] <= if_inst;
            pc_mem_q[tail_q]   <= if_pc;
        end
    end

    assign iq_full = iq_full_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: vector table, scoreboard model and corner-case sequences.
module tb_inst_queue;

    localparam int unsigned DEPTH = 16;
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        if_inst_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        iq_full;
    logic        dec_inst_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .clear          (clear),
        .if_inst_valid  (if_inst_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .iq_full        (iq_full),
        .dec_inst_valid (dec_inst_valid),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        rd;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_full;
    } vec_t;

    ent_t sb[$];
    logic model_full;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_drop = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hBEEF, pc[31:16] ^ 16'h1234};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; if_inst_valid = 1'b0;
        if_inst = '0; if_pc = '0; dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_full = 1'b0;
        #1;
        chk("rst_valid", dec_inst_valid, 0);
        chk("rst_pc", dec_pc, 0);
        chk("rst_inst", dec_inst, 0);
        chk("rst_full", iq_full, 0);
    endtask

    // One clock: check show-ahead outputs pre-edge, update the model, then check post-edge state.
    task automatic drive(input logic v, input logic [31:0] pc, input logic rd,
                         input logic clr, input logic rdy_g);
        int unsigned sz;
        logic        ce;
        logic        byp;
        logic        popped;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        ent_t        e;
        if_inst_valid = v; if_pc = pc; if_inst = inst_of(pc);
        dec_ready = rd; clear = clr; rdy = rdy_g;
        #1;
        sz  = sb.size();
        ce  = rdy_g && clr;
        byp = BYP && (sz == 0) && v && !ce;
        ev = 1'b0; epc = '0; einst = '0;
        if (!ce && sz != 0) begin
            ev = 1'b1; epc = sb[0].pc; einst = sb[0].inst;
        end else if (byp) begin
            ev = 1'b1; epc = pc; einst = inst_of(pc);
        end
        chk("pre_valid", dec_inst_valid, ev);
        chk("pre_pc", dec_pc, epc);
        chk("pre_inst", dec_inst, einst);
        if (rdy_g) begin
            if (ce) begin
                sb.delete();
            end else begin
                popped = (sz != 0) && rd;
                if (popped) void'(sb.pop_front());
                if (v && !(byp && rd)) begin
                    if (sz < DEPTH || popped) begin
                        e.inst = inst_of(pc); e.pc = pc;
                        sb.push_back(e);
                    end else begin
                        n_drop++;
                        $display("note: push of pc %h dropped on full queue (fetch protocol violation)", pc);
                    end
                end
            end
            model_full = (sb.size() >= DEPTH - 1);
        end
        @(posedge clk);
        #1;
        if_inst_valid = 1'b0; dec_ready = 1'b0; clear = 1'b0; rdy = 1'b1;
        #1;
        chk("post_full", iq_full, model_full);
        chk("post_valid", dec_inst_valid, sb.size() != 0);
        chk("post_pc", dec_pc, (sb.size() != 0) ? sb[0].pc : 32'h0);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            c++;
        end
        chk("drain_done", sb.size(), 0);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
        tbl[1] = '{1'b1, 32'h4, 1'b0, 1'b1, 32'h0, 1'b0};
        tbl[2] = '{1'b1, 32'h8, 1'b0, 1'b1, 32'h0, 1'b0};
        tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0};
        tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].rd, 1'b0, 1'b1);
            chk("tbl_valid", dec_inst_valid, tbl[i].exp_valid);
            chk("tbl_pc", dec_pc, tbl[i].exp_pc);
            chk("tbl_full", iq_full, tbl[i].exp_full);
        end

        // Fill to the almost-full threshold, then the in-flight push, then an overflow.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
            if (i == 13) chk("full_at14", iq_full, 0);
        end
        chk("full_at15", iq_full, 1);
        drive(1'b1, 32'h1100, 1'b0, 1'b0, 1'b1);
        chk("full_at16", iq_full, 1);
        drive(1'b1, 32'h1104, 1'b0, 1'b0, 1'b1);
        chk("head_after_drop", dec_pc, 32'h1000);

        // Full queue: simultaneous push and pop lands in the wrapped slot 0.
        drive(1'b1, 32'h3000, 1'b1, 1'b0, 1'b1);
        chk("full_pushpop", iq_full, 1);
        chk("head_advanced", dec_pc, 32'h1004);
        drain(40);

        // rdy low freezes everything.
        drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h504, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h508, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h50C, 1'b1, 1'b0, 1'b0);
        chk("hold_head", dec_pc, 32'h500);
        drain(10);

        // Long stream with random decoder stalls across pointer wrap.
        begin
            int pushed = 0;
            int cyc    = 0;
            logic v;
            while (pushed < 40 && cyc < 2000) begin
                v = !iq_full;
                drive(v, 32'h8000 + 32'(pushed * 4), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
                if (v) pushed++;
                cyc++;
            end
            chk("stream_pushed", pushed, 40);
            drain(100);
        end

        // Clear with a same-cycle push on a 5-entry queue.
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h900 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h9999, 1'b1, 1'b1, 1'b1);
        chk("clr_valid", dec_inst_valid, 0);
        chk("clr_full", iq_full, 0);
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        chk("after_clr_pc", dec_pc, 32'h200);
        drain(10);

        // Empty queue, push with decoder ready: bypass vs. stored latency.
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
`ifdef IQ_BYPASS_EN
        chk("byp_post_valid", dec_inst_valid, 0);
`else
        chk("nobyp_post_valid", dec_inst_valid, 1);
        chk("nobyp_post_pc", dec_pc, 32'h100);
`endif
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
